// File: rtl/pooling_bram_writer_pkg.sv
// pooling_bram_writer_pkg: shared widths, writer FSM states and bank one-hot codes
// for the 4-bank pooling buffer.
package pooling_bram_writer_pkg;

    localparam int BRAM_DATA_WIDTH  = 16;
    localparam int BRAM_ADDR_WIDTH  = 10;
    localparam int IMAGE_SIZE_WIDTH = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_FLUSH,
        S_DONE,
        S_WAIT_RD
    } state_t;

    // Bank index follows {row parity, col parity}; the read controller relies on the same mapping.
    localparam logic [3:0] BANK1 = 4'b0001;
    localparam logic [3:0] BANK2 = 4'b0010;
    localparam logic [3:0] BANK3 = 4'b0100;
    localparam logic [3:0] BANK4 = 4'b1000;

endpackage

// File: rtl/pooling_bram_writer_addr_gen.sv
// pooling_bram_addr_gen: raster row/col counters turned into a bank one-hot and
// a per-bank address, where each address holds one 2x2 window position.
module pooling_bram_addr_gen #(
    parameter int BRAM_ADDR_WIDTH  = 10,
    parameter int IMAGE_SIZE_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_init,
    input  logic [IMAGE_SIZE_WIDTH-1:0] i_width,
    input  logic [IMAGE_SIZE_WIDTH-1:0] i_height,
    input  logic                        i_advance,
    output logic [3:0]                  o_bank,
    output logic [BRAM_ADDR_WIDTH-1:0]  o_addr,
    output logic                        o_last
);
    import pooling_bram_writer_pkg::*;

    logic [IMAGE_SIZE_WIDTH-1:0] r_width;
    logic [IMAGE_SIZE_WIDTH-1:0] r_height;
    logic [IMAGE_SIZE_WIDTH-1:0] r_col;
    logic [IMAGE_SIZE_WIDTH-1:0] r_row;
    logic [BRAM_ADDR_WIDTH-1:0]  r_row_base;
    logic [BRAM_ADDR_WIDTH-1:0]  r_row_pitch;
    logic [IMAGE_SIZE_WIDTH:0]   w_pitch_full;
    logic                        w_col_last;

    assign w_pitch_full = ({1'b0, i_width} + 1'b1) >> 1;
    assign w_col_last   = r_col == r_width - 1'b1;
    assign o_last       = w_col_last && (r_row == r_height - 1'b1);
    assign o_bank       = r_row[0] ? (r_col[0] ? BANK4 : BANK3) : (r_col[0] ? BANK2 : BANK1);
    assign o_addr       = r_row_base + BRAM_ADDR_WIDTH'(r_col >> 1);

    // An even/odd row pair shares one address range, so the base only moves after odd rows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_width     <= '0;
            r_height    <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_row_base  <= '0;
            r_row_pitch <= '0;
        end else if (i_init) begin
            r_width     <= i_width;
            r_height    <= i_height;
            r_col       <= '0;
            r_row       <= '0;
            r_row_base  <= '0;
            r_row_pitch <= BRAM_ADDR_WIDTH'(w_pitch_full);
        end else if (i_advance) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
                if (r_row[0])
                    r_row_base <= r_row_base + r_row_pitch;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pooling_bram_writer.sv
// pooling_bram_writer: scatters a raster pixel stream over four BRAM banks by
// row/col parity, pulses frame_ready after the last write, then waits for the reader.
module pooling_bram_writer #(
    parameter int BRAM_DATA_WIDTH  = pooling_bram_writer_pkg::BRAM_DATA_WIDTH,
    parameter int BRAM_ADDR_WIDTH  = pooling_bram_writer_pkg::BRAM_ADDR_WIDTH,
    parameter int IMAGE_SIZE_WIDTH = pooling_bram_writer_pkg::IMAGE_SIZE_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [IMAGE_SIZE_WIDTH-1:0] image_width,
    input  logic [IMAGE_SIZE_WIDTH-1:0] image_hight,
    input  logic [BRAM_DATA_WIDTH-1:0]  pixel_in,
    input  logic                        pixel_in_valid,
    output logic                        pixel_in_ready,
    input  logic                        reader_busy,
    output logic [3:0]                  bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_addr,
    output logic [BRAM_DATA_WIDTH-1:0]  bram_wdata,
    output logic                        frame_ready,
    output logic                        busy
);
    import pooling_bram_writer_pkg::*;

    state_t                     r_state;
    logic [3:0]                 r_we;
    logic [BRAM_ADDR_WIDTH-1:0] r_addr;
    logic [BRAM_DATA_WIDTH-1:0] r_wdata;
    logic                       r_frame_ready;
    logic [3:0]                 w_bank;
    logic [BRAM_ADDR_WIDTH-1:0] w_addr;
    logic                       w_last;
    logic                       w_accept;
    logic                       w_init;

    assign pixel_in_ready = r_state == S_FILL;
    assign busy           = r_state != S_IDLE;
    assign w_accept       = pixel_in_valid && pixel_in_ready;
    assign w_init         = start && (r_state == S_IDLE);
    assign bram_we        = r_we;
    assign bram_addr      = r_addr;
    assign bram_wdata     = r_wdata;
    assign frame_ready    = r_frame_ready;

    pooling_bram_addr_gen #(
        .BRAM_ADDR_WIDTH (BRAM_ADDR_WIDTH),
        .IMAGE_SIZE_WIDTH(IMAGE_SIZE_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .i_init   (w_init),
        .i_width  (image_width),
        .i_height (image_hight),
        .i_advance(w_accept),
        .o_bank   (w_bank),
        .o_addr   (w_addr),
        .o_last   (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_we          <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_frame_ready <= 1'b0;
        end else begin
            r_we          <= w_accept ? w_bank : 4'b0000;
            r_frame_ready <= r_state == S_FLUSH;
            if (w_accept) begin
                r_addr  <= w_addr;
                r_wdata <= pixel_in;
            end
            case (r_state)
                S_IDLE:    if (start) r_state <= S_FILL;
                S_FILL:    if (w_accept && w_last) r_state <= S_FLUSH;
                S_FLUSH:   r_state <= S_DONE;
                S_DONE:    r_state <= S_WAIT_RD;
                S_WAIT_RD: if (!reader_busy) r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

endmodule
